// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the request-legality check for the LSU.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_FAULT      = 2'd2
  } lsu_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request as latched in IDLE; everything downstream works off this copy.
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Illegal funct3 for the direction, or an access that would straddle the word.
  function automatic logic is_bad_access(input logic write, input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic illegal;
    logic misal;
    if (write) illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else       illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    misal = ((funct3[1:0] == 2'b01) && (offset == 2'b11)) ||
            ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return illegal | misal;
  endfunction

endpackage

// File: rtl/load_memory_decoder.sv
// Extracts and extends a load result from a read word given funct3 and byte offset.
module load_memory_decoder
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        exc
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Select size and extension; flag encodings/offsets a load cannot legally use.
  always_comb begin
    data = '0;
    exc  = 1'b0;
    case (funct3)
      F3_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  begin
        data = {{16{shifted[15]}}, shifted[15:0]};
        exc  = (offset == 2'b11);
      end
      F3_W:  begin
        data = shifted;
        exc  = (offset != 2'b00);
      end
      F3_BU: data = {24'b0, shifted[7:0]};
      F3_HU: begin
        data = {16'b0, shifted[15:0]};
        exc  = (offset == 2'b11);
      end
      default: exc = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between execute and the data-memory bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_cause
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  lsu_req_t    req_q;
  lsu_cause_t  cause_q;
  logic [31:0] rdata_q;
  logic [15:0] cnt;
  logic        bad;
  logic        timeout;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;
  logic        ld_exc;

  assign bad     = is_bad_access(req_write, req_funct3, req_addr[1:0]);
  assign timeout = (cnt == TO_LAST);
  assign off     = req_q.addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Latch the request, the read word, the cause and the WAIT timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      cause_q <= CAUSE_NONE;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_q   <= '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          cause_q <= bad ? CAUSE_MISALIGNED : CAUSE_NONE;
          rdata_q <= '0;
        end
        S_ISSUE: if (mem_ready) cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 16'd1;
          // A response in the timeout cycle still counts as a response.
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            if (mem_err) cause_q <= CAUSE_FAULT;
          end else if (timeout) begin
            cause_q <= CAUSE_FAULT;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and the handshake outputs, all decoded from state.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = S_WAIT;
      end
      S_WAIT: if (mem_rvalid || timeout) state_nxt = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Store byte lanes: strobe shifted by offset, data replicated across lanes.
  always_comb begin
    strb      = '0;
    wdata_rep = '0;
    if (req_q.write) begin
      case (req_q.funct3)
        F3_B: begin
          strb      = 4'b0001 << off;
          wdata_rep = {4{req_q.wdata[7:0]}};
        end
        F3_H: begin
          strb      = 4'b0011 << off;
          wdata_rep = {2{req_q.wdata[15:0]}};
        end
        F3_W: begin
          strb      = 4'b1111;
          wdata_rep = req_q.wdata;
        end
        default: ;
      endcase
    end
  end

  load_memory_decoder u_dec (
    .funct3 (req_q.funct3),
    .offset (off),
    .rdata  (rdata_q),
    .data   (ld_data),
    .exc    (ld_exc)
  );

  assign mem_addr   = mem_valid ? {req_q.addr[31:2], 2'b00} : '0;
  assign mem_we     = mem_valid & req_q.write;
  assign mem_wstrb  = mem_valid ? strb : '0;
  assign mem_wdata  = mem_valid ? wdata_rep : '0;
  assign resp_cause = resp_valid ? cause_q : CAUSE_NONE;
  assign resp_data  = (resp_valid && !req_q.write && cause_q == CAUSE_NONE && !ld_exc) ? ld_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a spec-level model and a per-cycle checker.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_write = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready;
  logic        mem_valid, mem_we;
  logic        mem_ready = 0, mem_rvalid = 0, mem_err = 0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_ready = 0;
  logic [31:0] resp_data;
  logic [1:0]  resp_cause;

  int tests = 0, fails = 0;

  logic        chk_en = 0;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic        exp_we;
  logic [3:0]  exp_strb;
  logic [1:0]  exp_cause;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_cause(resp_cause)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---- model: access size in bytes, legality, lanes, load extension ----
  function automatic int m_size(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit m_bad(input bit w, input logic [2:0] f, input logic [1:0] off);
    if (w ? (f > 3'd2) : (f == 3'd3 || f >= 3'd6)) return 1'b1;
    return (int'(off) + m_size(f)) > 4;
  endfunction

  function automatic logic [3:0] m_strb(input bit w, input logic [2:0] f, input logic [1:0] off);
    if (!w) return 4'd0;
    return 4'(((1 << m_size(f)) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = m_size(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz   = m_size(f);
    v    = rd >> (8 * int'(off));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
    v    = v & mask;
    if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Per-cycle compare against the model's expectations for the current transaction.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (mem_valid) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (resp_valid) begin
        check("resp_data", resp_data, exp_data);
        check("resp_cause", 32'(resp_cause), 32'(exp_cause));
      end
      if (req_ready) check("ready_excl", 32'(mem_valid | resp_valid), 32'd0);
    end
  end

  // One full transaction: issue request, play the memory, collect the response.
  task automatic run_req(input string tag, input bit w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int rdly, input int rvdly, input bit no_rv,
                         input logic [31:0] rd, input bit err, input int hold,
                         output int lat, output int issued, output logic [31:0] g_data,
                         output logic [1:0] g_cause, output logic [3:0] g_strb,
                         output logic [31:0] g_addr, output logic [31:0] g_wdata);
    bit bad, got;
    int waited;
    bad       = m_bad(w, f, a[1:0]);
    exp_addr  = a & ~32'h3;
    exp_we    = w;
    exp_strb  = m_strb(w, f, a[1:0]);
    exp_wdata = m_wdata(f, wd);
    if (bad)               begin exp_data = 0; exp_cause = 2'd1; end
    else if (err || no_rv) begin exp_data = 0; exp_cause = 2'd2; end
    else if (w)            begin exp_data = 0; exp_cause = 2'd0; end
    else                   begin exp_data = m_load(f, a[1:0], rd); exp_cause = 2'd0; end
    lat = 0; issued = 0; waited = 0; got = 0;
    g_data = 0; g_cause = 0; g_strb = 0; g_addr = 0; g_wdata = 0;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 0;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(negedge clk);
      mem_ready = 0; mem_rvalid = 0; mem_err = 0;
      if (resp_valid) begin
        got = 1; lat = c; g_data = resp_data; g_cause = resp_cause;
      end else if (mem_valid) begin
        if (issued == 0) begin g_strb = mem_wstrb; g_addr = mem_addr; g_wdata = mem_wdata; end
        issued++;
        if (issued > rdly) mem_ready = 1;
      end else begin
        waited++;
        if (!no_rv && waited > rvdly) begin mem_rvalid = 1; mem_rdata = rd; mem_err = err; end
      end
    end
    check({tag, "_got_resp"}, 32'(got), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_resp_held"}, 32'(resp_valid), 32'd1);
    end
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    @(negedge clk);
    check({tag, "_back_idle"}, 32'(req_ready), 32'd1);
  endtask

  int          lat, iss;
  logic [31:0] gd, ga, gw;
  logic [1:0]  gc;
  logic [3:0]  gs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_cause", 32'(resp_cause), 32'd0);
    rst_n = 1;
    chk_en = 1;

    run_req("lb", 0, F3_B, 32'h1003, 0, 0, 0, 0, 32'hBF00_0000, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lb_addr", ga, 32'h1000);
    check("lb_strb", 32'(gs), 32'd0);
    check("lb_data", gd, 32'hFFFF_FFBF);
    check("lb_cause", 32'(gc), 32'd0);
    check("lb_lat", lat, 3);

    run_req("sh", 1, F3_H, 32'h2002, 32'h1234_ABCD, 3, 0, 0, 0, 0, 2, lat, iss, gd, gc, gs, ga, gw);
    check("sh_issue_cycles", iss, 4);
    check("sh_strb", 32'(gs), 32'hC);
    check("sh_wdata", gw, 32'hABCD_ABCD);
    check("sh_data", gd, 32'd0);
    check("sh_cause", 32'(gc), 32'd0);
    check("sh_lat", lat, 6);

    run_req("lw_mis", 0, F3_W, 32'h0001, 0, 0, 0, 0, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lw_mis_cause", 32'(gc), 32'd1);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_nobus", iss, 0);

    run_req("lh_mis", 0, F3_H, 32'h0003, 0, 0, 0, 0, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lh_mis_cause", 32'(gc), 32'd1);
    check("lh_mis_lat", lat, 1);
    check("lh_mis_nobus", iss, 0);

    run_req("ld_f6", 0, 3'b110, 32'h0000, 0, 0, 0, 0, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("ld_f6_cause", 32'(gc), 32'd1);
    check("ld_f6_nobus", iss, 0);

    run_req("st_f3", 1, 3'b011, 32'h0000, 32'h1111_2222, 0, 0, 0, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("st_f3_cause", 32'(gc), 32'd1);
    check("st_f3_nobus", iss, 0);

    run_req("lhu_err", 0, F3_HU, 32'h0002, 0, 0, 0, 0, 32'hFFFF_0000, 1, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lhu_err_cause", 32'(gc), 32'd2);
    check("lhu_err_data", gd, 32'd0);

    run_req("lw_to", 0, F3_W, 32'h0010, 0, 0, 0, 1, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lw_to_cause", 32'(gc), 32'd2);
    check("lw_to_data", gd, 32'd0);
    check("lw_to_lat", lat, 2 + TO);

    // Late response arriving while idle must be dropped.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; mem_err = 1;
      check("late_rv_idle", 32'(req_ready), 32'd1);
      check("late_rv_noresp", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    mem_rvalid = 0; mem_err = 0;
    check("late_rv_after", 32'(resp_valid), 32'd0);

    run_req("lbu", 0, F3_BU, 32'h0101, 0, 0, 0, 0, 32'h0000_FF00, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lbu_data", gd, 32'h0000_00FF);
    check("lbu_cause", 32'(gc), 32'd0);
    check("lbu_lat", lat, 3);

    run_req("sb", 1, F3_B, 32'h3001, 32'h0000_0055, 1, 1, 0, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("sb_strb", 32'(gs), 32'h2);
    check("sb_wdata", gw, 32'h5555_5555);
    check("sb_addr", ga, 32'h3000);

    run_req("lh_off1", 0, F3_H, 32'h0001, 0, 0, 2, 0, 32'h0080_7F00, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("lh_off1_data", gd, 32'hFFFF_807F);
    check("lh_off1_lat", lat, 5);

    run_req("sw", 1, F3_W, 32'h4000, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("sw_strb", 32'(gs), 32'hF);
    check("sw_wdata", gw, 32'hCAFE_F00D);
    check("sw_cause", 32'(gc), 32'd0);

    // Reset while the request is on the bus.
    chk_en = 0;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_funct3 = F3_W; req_addr = 32'h40;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    check("rst_issue_pre", 32'(mem_valid), 32'd1);
    #2 rst_n = 0;
    #1 check("rst_issue_memv", 32'(mem_valid), 32'd0);
    @(negedge clk); rst_n = 1;

    // Reset while waiting for the response.
    @(negedge clk);
    req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); mem_ready = 1;
    @(negedge clk); mem_ready = 0;
    #2 rst_n = 0;
    #1 check("rst_wait_memv", 32'(mem_valid), 32'd0);
    check("rst_wait_respv", 32'(resp_valid), 32'd0);
    @(negedge clk); rst_n = 1;
    repeat (TO + 2) @(negedge clk);
    check("rst_wait_ready", 32'(req_ready), 32'd1);
    check("rst_wait_noresp", 32'(resp_valid), 32'd0);
    chk_en = 1;

    run_req("post_rst", 0, F3_W, 32'h0044, 0, 0, 0, 0, 32'h1357_9BDF, 0, 0, lat, iss, gd, gc, gs, ga, gw);
    check("post_rst_data", gd, 32'h1357_9BDF);
    check("post_rst_lat", lat, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
